// File: rtl/ddr2_cmd_arbiter_pkg.sv
// Shared definitions for the two-port DDR2 command arbiter: command field layout,
// widths, FSM encoding and field-extraction helpers.
package ddr2_cmd_arbiter_pkg;

   localparam int CMD_W    = 34;
   localparam int DATA_W   = 128;
   localparam int LEN_W    = 7;

   localparam int RD_BIT   = 33;
   localparam int LEN_MSB  = 32;
   localparam int LEN_LSB  = 26;
   localparam int ADDR_MSB = 25;
   localparam int ADDR_LSB = 0;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CMD_WAIT = 3'd1,
      CMD_GAP  = 3'd2,
      WR_WAIT  = 3'd3,
      WR_GAP   = 3'd4
   } arb_state_t;

   function automatic logic [LEN_W-1:0] cmd_len(input logic [CMD_W-1:0] cmd);
      return cmd[LEN_MSB:LEN_LSB];
   endfunction

   function automatic logic cmd_is_rd(input logic [CMD_W-1:0] cmd);
      return cmd[RD_BIT];
   endfunction

endpackage

// File: rtl/ddr2_cmd_arbiter_pick.sv
// Two-way combinational picker: request valids (+ tie pointer) to a one-hot grant.
// DDR2_ARB_RR_EN selects round-robin; otherwise port 0 has fixed priority.
module ddr2_arb_pick (
   input  logic [1:0] valid,
`ifdef DDR2_ARB_RR_EN
   input  logic       ptr,
`endif
   output logic [1:0] gnt
);

   // One-hot winner selection; a lone requester always wins.
   always_comb begin
      gnt = 2'b00;
`ifdef DDR2_ARB_RR_EN
      if (valid == 2'b11) begin
         if (ptr) begin
            gnt = 2'b10;
         end else begin
            gnt = 2'b01;
         end
      end else begin
         gnt = valid;
      end
`else
      if (valid[0]) begin
         gnt = 2'b01;
      end else if (valid[1]) begin
         gnt = 2'b10;
      end else begin
         gnt = 2'b00;
      end
`endif
   end

endmodule

// File: rtl/ddr2_cmd_arbiter.sv
// Arbitrates two requesters onto the DDR2 input controller's command and write-data ports.
// Define DDR2_ARB_RR_EN for round-robin arbitration; default is fixed priority (port 0).
module ddr2_cmd_arbiter
   import ddr2_cmd_arbiter_pkg::*;
(
   input  logic              ddr2_clk,
   input  logic              sys_rst_n,

   input  logic              req0_cmd_valid,
   input  logic [CMD_W-1:0]  req0_cmd,
   output logic              req0_cmd_ack,
   input  logic              req0_data_valid,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_data_ack,

   input  logic              req1_cmd_valid,
   input  logic [CMD_W-1:0]  req1_cmd,
   output logic              req1_cmd_ack,
   input  logic              req1_data_valid,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_data_ack,

   input  logic              um2ddr_command_ready,
   output logic              um2ddr_command_wrreq,
   output logic [CMD_W-1:0]  um2ddr_command,

   input  logic              um2ddr_data_ready,
   output logic              um2ddr_wrreq,
   output logic [DATA_W-1:0] um2ddr_data,

   output logic [1:0]        grant,
   output logic              busy,
   output logic              err_zero_len
);

   arb_state_t        state_r;
   logic [CMD_W-1:0]  cmd_r;
   logic [LEN_W-1:0]  beat_cnt_r;
   logic [1:0]        grant_r;
   logic              busy_r;
   logic              err_zero_len_r;
   logic              req0_cmd_ack_r;
   logic              req1_cmd_ack_r;
   logic              req0_data_ack_r;
   logic              req1_data_ack_r;
   logic              cmd_wrreq_r;
   logic [CMD_W-1:0]  command_r;
   logic              wrreq_r;
   logic [DATA_W-1:0] data_r;

   logic [1:0]        cmd_valid_s;
   logic [1:0]        pick_s;
   logic [CMD_W-1:0]  cmd_sel_s;
   logic              data_valid_s;
   logic [DATA_W-1:0] data_sel_s;

   assign cmd_valid_s = {req1_cmd_valid, req0_cmd_valid};

`ifdef DDR2_ARB_RR_EN
   logic rr_ptr_r;

   ddr2_arb_pick u_pick (
      .valid (cmd_valid_s),
      .ptr   (rr_ptr_r),
      .gnt   (pick_s)
   );

   // Tie pointer prefers the port after the last one served (zero-length commands count).
   always_ff @(posedge ddr2_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rr_ptr_r <= 1'b0;
      end else if ((state_r == IDLE) && (pick_s != 2'b00)) begin
         rr_ptr_r <= pick_s[0];
      end
   end
`else
   ddr2_arb_pick u_pick (
      .valid (cmd_valid_s),
      .gnt   (pick_s)
   );
`endif

   // Winner command mux and granted-port write-data mux; a non-granted port is never seen.
   always_comb begin
      cmd_sel_s    = req0_cmd;
      data_valid_s = 1'b0;
      data_sel_s   = {DATA_W{1'b0}};
      if (pick_s[1]) begin
         cmd_sel_s = req1_cmd;
      end else begin
         cmd_sel_s = req0_cmd;
      end
      if (grant_r[1]) begin
         data_valid_s = req1_data_valid;
         data_sel_s   = req1_data;
      end else if (grant_r[0]) begin
         data_valid_s = req0_data_valid;
         data_sel_s   = req0_data;
      end else begin
         data_valid_s = 1'b0;
         data_sel_s   = {DATA_W{1'b0}};
      end
   end

   // Main FSM; every strobe is a registered single-cycle pulse, and each GAP state waits for
   // the ready line to drop so only one request is issued per ready-high window.
   always_ff @(posedge ddr2_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_r         <= IDLE;
         cmd_r           <= {CMD_W{1'b0}};
         beat_cnt_r      <= {LEN_W{1'b0}};
         grant_r         <= 2'b00;
         busy_r          <= 1'b0;
         err_zero_len_r  <= 1'b0;
         req0_cmd_ack_r  <= 1'b0;
         req1_cmd_ack_r  <= 1'b0;
         req0_data_ack_r <= 1'b0;
         req1_data_ack_r <= 1'b0;
         cmd_wrreq_r     <= 1'b0;
         command_r       <= {CMD_W{1'b0}};
         wrreq_r         <= 1'b0;
         data_r          <= {DATA_W{1'b0}};
      end else begin
         req0_cmd_ack_r  <= 1'b0;
         req1_cmd_ack_r  <= 1'b0;
         req0_data_ack_r <= 1'b0;
         req1_data_ack_r <= 1'b0;
         cmd_wrreq_r     <= 1'b0;
         wrreq_r         <= 1'b0;
         err_zero_len_r  <= 1'b0;
         case (state_r)
            IDLE: begin
               if (pick_s != 2'b00) begin
                  req0_cmd_ack_r <= pick_s[0];
                  req1_cmd_ack_r <= pick_s[1];
                  if (cmd_len(cmd_sel_s) == {LEN_W{1'b0}}) begin
                     err_zero_len_r <= 1'b1;
                  end else begin
                     cmd_r   <= cmd_sel_s;
                     grant_r <= pick_s;
                     busy_r  <= 1'b1;
                     state_r <= CMD_WAIT;
                  end
               end
            end
            CMD_WAIT: begin
               if (um2ddr_command_ready) begin
                  cmd_wrreq_r <= 1'b1;
                  command_r   <= cmd_r;
                  state_r     <= CMD_GAP;
               end
            end
            CMD_GAP: begin
               if (!um2ddr_command_ready) begin
                  if (cmd_is_rd(cmd_r)) begin
                     grant_r <= 2'b00;
                     busy_r  <= 1'b0;
                     state_r <= IDLE;
                  end else begin
                     beat_cnt_r <= cmd_len(cmd_r);
                     state_r    <= WR_WAIT;
                  end
               end
            end
            WR_WAIT: begin
               if (um2ddr_data_ready && data_valid_s) begin
                  wrreq_r         <= 1'b1;
                  req0_data_ack_r <= grant_r[0];
                  req1_data_ack_r <= grant_r[1];
                  data_r          <= data_sel_s;
                  if (beat_cnt_r != {LEN_W{1'b0}}) begin
                     beat_cnt_r <= beat_cnt_r - 7'd1;
                  end
                  state_r <= WR_GAP;
               end
            end
            WR_GAP: begin
               if (!um2ddr_data_ready) begin
                  if (beat_cnt_r == {LEN_W{1'b0}}) begin
                     grant_r <= 2'b00;
                     busy_r  <= 1'b0;
                     state_r <= IDLE;
                  end else begin
                     state_r <= WR_WAIT;
                  end
               end
            end
            default: begin
               grant_r <= 2'b00;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign req0_cmd_ack         = req0_cmd_ack_r;
   assign req1_cmd_ack         = req1_cmd_ack_r;
   assign req0_data_ack        = req0_data_ack_r;
   assign req1_data_ack        = req1_data_ack_r;
   assign um2ddr_command_wrreq = cmd_wrreq_r;
   assign um2ddr_command       = command_r;
   assign um2ddr_wrreq         = wrreq_r;
   assign um2ddr_data          = data_r;
   assign grant                = grant_r;
   assign busy                 = busy_r;
   assign err_zero_len         = err_zero_len_r;

endmodule

// File: doc/ddr2_cmd_arbiter.md
DDR2_CMD_ARBITER -- requirements
Module: ddr2_cmd_arbiter

Interface
REQ-001 SHALL have ports: ddr2_clk  in  1  clock; sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have ports: reqN_cmd_valid  in  1, reqN_cmd  in  34, reqN_cmd_ack  out  1, for N=0,1; command = {rd[33], len[32:26], addr[25:0]}.
REQ-003 SHALL have ports: reqN_data_valid  in  1, reqN_data  in  128, reqN_data_ack  out  1, for N=0,1; these carry write beats.
REQ-004 SHALL have ports: um2ddr_command_ready  in  1; um2ddr_command_wrreq  out  1; um2ddr_command  out  34; these go to the DDR2 input controller.
REQ-005 SHALL have ports: um2ddr_data_ready  in  1; um2ddr_wrreq  out  1; um2ddr_data  out  128; these go to the DDR2 input controller.
REQ-006 SHALL have ports: grant  out  2, a one-hot owner that is 0 when idle; busy  out  1; err_zero_len  out  1, a 1-cycle pulse.

Function
REQ-007 SHALL implement the FSM states IDLE, CMD_WAIT, CMD_GAP, WR_WAIT, WR_GAP.
REQ-008 IDLE: when any reqN_cmd_valid=1, the block SHALL select a winner, latch its command, and pulse reqN_cmd_ack for 1 cycle.
REQ-009 In the same cycle, the block SHALL set grant and busy=1, then go to CMD_WAIT.
REQ-010 Zero length (len=0) in IDLE: the block SHALL ack the command, pulse err_zero_len, and never forward it.
REQ-011 After a zero-length command, the block SHALL stay in IDLE, and arbitration SHALL advance as if the command were served.
REQ-012 CMD_WAIT: when um2ddr_command_ready=1, the block SHALL pulse um2ddr_command_wrreq for exactly 1 cycle with um2ddr_command = latched command, then go to CMD_GAP.
REQ-013 CMD_GAP: the block SHALL hold until um2ddr_command_ready=0.
REQ-014 On leaving CMD_GAP, a read SHALL return to IDLE, and a write SHALL load beat_cnt=len (7 bits, in 128-bit beats) and go to WR_WAIT.
REQ-015 WR_WAIT: when um2ddr_data_ready=1 and the granted reqN_data_valid=1, the block SHALL pulse um2ddr_wrreq and reqN_data_ack together for 1 cycle with um2ddr_data=reqN_data, decrement beat_cnt, and go to WR_GAP.
REQ-016 WR_GAP: the block SHALL hold until um2ddr_data_ready=0.
REQ-017 On leaving WR_GAP, the block SHALL go to IDLE if beat_cnt=0, otherwise to WR_WAIT.
REQ-018 The block SHALL issue at most one um2ddr_wrreq per um2ddr_data_ready high window and at most one um2ddr_command_wrreq per um2ddr_command_ready high window.
REQ-019 reqN_data_valid on a non-granted port SHALL be ignored, with no ack.
REQ-020 If the granted port stalls (data_valid=0) in WR_WAIT, the block SHALL wait indefinitely, with no timeout.
REQ-021 Requests arriving during a busy period SHALL wait; they are never acked before the current transaction ends.
REQ-022 On returning to IDLE, the block SHALL drop grant and busy in the same cycle the next arbitration may occur.
REQ-023 beat_cnt SHALL never wrap: decrement occurs only when beat_cnt>0.

Reset
REQ-024 On sys_rst_n=0, the block SHALL force all outputs to 0, state to IDLE, beat_cnt=0, latched command=0, and the RR pointer to port 0, immediately and regardless of clock.
REQ-025 Reset mid-transaction SHALL abandon the transaction; after release the block SHALL accept a new command in the first IDLE cycle.

Configuration
REQ-026 With macro DDR2_ARB_RR_EN defined, arbitration SHALL be round-robin.
REQ-027 Under round-robin, the pointer SHALL move to the port after the last served one, and on a simultaneous request the port opposite the last served wins.
REQ-028 Without DDR2_ARB_RR_EN, arbitration SHALL be fixed priority, with port 0 always winning ties, and the pointer logic SHALL be absent.

Structure
REQ-029 A shared package SHALL hold the command field positions (RD_BIT=33, LEN_MSB/LSB=32/26, ADDR_MSB/LSB=25/0), the state encoding, and the widths 34/128/7.
REQ-030 The design SHALL have one sub-module, ddr2_arb_pick, a 2-way combinational picker (valids, pointer -> one-hot grant) that switches mode on DDR2_ARB_RR_EN.

Verification
REQ-031 The bench SHALL cover: req0 write len=2, addr=0x100, ready pulses -> one command_wrreq with 0x0_0800_0100-form command, two um2ddr_wrreq with data A,B, two req0_data_ack pulses, grant=01 throughout.
REQ-032 The bench SHALL cover: req1 read len=4 -> one command_wrreq with bit33=1, no um2ddr_wrreq, return to IDLE after command_ready falls.
REQ-033 The bench SHALL cover: req0 and req1 valid continuously, RR_EN defined -> served order 0,1,0,1; without RR_EN -> 0,0,0.
REQ-034 The bench SHALL cover: req0 len=0 -> req0_cmd_ack plus err_zero_len in the same cycle, and no command_wrreq.
REQ-035 The bench SHALL cover: um2ddr_data_ready held high for 5 cycles during a len=3 write -> exactly one wrreq in that window.
REQ-036 The bench SHALL cover: sys_rst_n asserted in WR_WAIT after 1 of 3 beats -> outputs 0 asynchronously, then a new req1 command is accepted cleanly.
